// File: rtl/aes_uart_pkg.sv
// Shared types and constants for the AES cypher UART transmitter.
// Optional CR/LF trailer is enabled by defining AES_CYPHER_TX_CRLF_EN.
package aes_uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

  localparam int unsigned AES_BLOCK_BYTES = 16;
  localparam int unsigned UART_DATA_BITS  = 8;
  localparam logic        UART_START_BIT  = 1'b0;
  localparam logic        UART_STOP_BIT   = 1'b1;
  localparam logic [7:0]  ASCII_CR        = 8'h0D;
  localparam logic [7:0]  ASCII_LF        = 8'h0A;

endpackage

// File: rtl/aes_cypher_uart_tx_byte.sv
// 8N1 byte framer with bit-time counter; chains frames without gaps.
// Defines module uart_tx_byte.
module uart_tx_byte
  import aes_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_i,
  input  logic       more_i,
  input  logic [7:0] data_i,
  output logic       adv_o,
  output logic       idle_o,
  output logic       done_o,
  output logic       tx_o
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] BIT_LAST = 3'(UART_DATA_BITS - 1);

  uart_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          tx_q, tx_d;
  logic          done_q, done_d;
  logic          bit_end;

  // Next-state logic: one bit time per state step, LSB-first data.
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    adv_o   = 1'b0;
    bit_end = (cnt_q == CNT_MAX);
    cnt_d   = bit_end ? '0 : cnt_q + 1'b1;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start_i) begin
          state_d = START;
          sh_d    = data_i;
          tx_d    = UART_START_BIT;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
          tx_d    = sh_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == BIT_LAST) begin
            state_d = STOP;
            tx_d    = UART_STOP_BIT;
          end else begin
            bit_d = bit_q + 1'b1;
            sh_d  = sh_q >> 1;
            tx_d  = sh_q[1];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (more_i) begin
            state_d = START;
            sh_d    = data_i;
            tx_d    = UART_START_BIT;
            adv_o   = 1'b1;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset parks the line idle-high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      tx_q    <= UART_STOP_BIT;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  assign idle_o = (state_q == IDLE);
  assign done_o = done_q;
  assign tx_o   = tx_q;

endmodule

// File: rtl/aes_cypher_uart_tx.sv
// Serializes 128-bit AES cypher blocks over an 8N1 UART, byte 0 first.
// AES_CYPHER_TX_CRLF_EN appends a CR/LF frame pair after each block.
module aes_cypher_uart_tx
  import aes_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cypher_valid,
  input  logic [127:0] cypher,
  output logic         cypher_ready,
  output logic         busy,
  output logic         done,
  output logic         tx
);

  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_cpb
    $error("CLKS_PER_BIT must be in 2..65535");
  end

`ifdef AES_CYPHER_TX_CRLF_EN
  localparam int unsigned TOTAL = AES_BLOCK_BYTES + 2;
`else
  localparam int unsigned TOTAL = AES_BLOCK_BYTES;
`endif
  localparam int unsigned BW = $clog2(TOTAL + 1);
  localparam logic [BW-1:0] LAST = BW'(TOTAL);

  logic [127:0]  sh_q, sh_d;
  logic [BW-1:0] cnt_q, cnt_d;
  logic [7:0]    byte_w;
  logic          idle, accept, more, adv;

  assign accept = cypher_valid & idle;
  assign more   = (cnt_q != LAST);

  // Pick the next byte: straight from the input on accept, else the shifter.
  always_comb begin
    byte_w = sh_q[127:120];
    if (accept) begin
      byte_w = cypher[127:120];
    end
`ifdef AES_CYPHER_TX_CRLF_EN
    else if (cnt_q == BW'(AES_BLOCK_BYTES)) begin
      byte_w = ASCII_CR;
    end else if (cnt_q == BW'(AES_BLOCK_BYTES + 1)) begin
      byte_w = ASCII_LF;
    end
`endif
  end

  // Byte shifter and sent-byte counter; the counter stops at the last byte.
  always_comb begin
    sh_d  = sh_q;
    cnt_d = cnt_q;
    if (accept) begin
      sh_d  = {cypher[119:0], 8'h00};
      cnt_d = BW'(1);
    end else if (adv) begin
      sh_d  = {sh_q[119:0], 8'h00};
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Block registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk    (clk),
    .reset  (reset),
    .start_i(accept),
    .more_i (more),
    .data_i (byte_w),
    .adv_o  (adv),
    .idle_o (idle),
    .done_o (done),
    .tx_o   (tx)
  );

  assign cypher_ready = idle;
  assign busy         = ~idle;

endmodule

// File: tb/tb_aes_cypher_uart_tx.sv
// Self-checking bench for aes_cypher_uart_tx with CLKS_PER_BIT=4.
// Honours AES_CYPHER_TX_CRLF_EN when the design is built with it.
module tb_aes_cypher_uart_tx;

  localparam int CPB = 4;
`ifdef AES_CYPHER_TX_CRLF_EN
  localparam int FR = 18;
`else
  localparam int FR = 16;
`endif
  localparam int L = FR * 10 * CPB;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         cypher_valid = 1'b0;
  logic [127:0] cypher = '0;
  logic         cypher_ready, busy, done, tx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  aes_cypher_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .reset       (reset),
    .cypher_valid(cypher_valid),
    .cypher      (cypher),
    .cypher_ready(cypher_ready),
    .busy        (busy),
    .done        (done),
    .tx          (tx)
  );

  function automatic logic [7:0] exp_byte(logic [127:0] blk, int f);
    if (f < 16) return blk[127 - 8 * f -: 8];
    else if (f == 16) return 8'h0D;
    else return 8'h0A;
  endfunction

  // Expected line level at cycle idx counted from the first start bit.
  function automatic logic exp_level(logic [127:0] blk, int idx);
    int b, f, p;
    logic [7:0] v;
    b = idx / CPB;
    f = b / 10;
    p = b % 10;
    v = exp_byte(blk, f);
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return v[p - 1];
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd_blk();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Present a block at a negedge; returns at the negedge after the transfer.
  task automatic offer(input logic [127:0] blk);
    cypher       = blk;
    cypher_valid = 1'b1;
    chk("ready_before_offer", cypher_ready, 1);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Follow one block's waveform cycle by cycle against the model.
  task automatic stream(input logic [127:0] blk, input bit chain,
                        input logic [127:0] nxt, input int abort_at);
    int         bad;
    int         first;
    int         p;
    logic       hs_bad;
    logic [7:0] got [FR];
    bad    = 0;
    first  = -1;
    hs_bad = 1'b0;
    if (chain) cypher = nxt;
    else cypher_valid = 1'b0;
    for (int i = 0; i < L; i++) begin
      if (abort_at >= 0 && i == abort_at) begin
        chk($sformatf("partial_stream first_bad=%0d", first), bad, 0);
        return;
      end
      if (tx !== exp_level(blk, i)) begin
        bad++;
        if (first < 0) first = i;
      end
      if (busy !== 1'b1 || cypher_ready !== 1'b0 || done !== 1'b0)
        hs_bad = 1'b1;
      p = (i / CPB) % 10;
      if (p >= 1 && p <= 8 && (i % CPB) == CPB / 2)
        got[i / (10 * CPB)][p - 1] = tx;
      @(negedge clk);
    end
    chk($sformatf("stream first_bad=%0d", first), bad, 0);
    chk("handshake_in_flight", hs_bad, 0);
    for (int f = 0; f < FR; f++)
      chk($sformatf("decoded_byte%0d", f), got[f], exp_byte(blk, f));
    chk("done_pulse", done, 1);
    chk("ready_at_done", cypher_ready, 1);
    chk("busy_at_done", busy, 0);
    chk("tx_idle_at_done", tx, 1);
    if (chain) begin
      @(posedge clk);
      @(negedge clk);
    end else begin
      @(negedge clk);
      chk("done_one_cycle", done, 0);
      chk("tx_idle_after", tx, 1);
    end
  endtask

  initial begin
    logic [127:0] r1, r2;
    int idle_bad;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_ready", cypher_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);

    // Known block, offered on the first edge with reset released
    reset = 1'b1;
    offer(128'hff0b844a0853bf7c6934ab4364148fb9);
    stream(128'hff0b844a0853bf7c6934ab4364148fb9, 1'b0, '0, -1);

    // Valid held high with another block while busy; back-to-back blocks
    r1 = rnd_blk();
    r2 = rnd_blk();
    offer(r1);
    stream(r1, 1'b1, r2, -1);
    stream(r2, 1'b0, '0, -1);

    // All zeros then all ones, chained
    offer('0);
    stream('0, 1'b1, {128{1'b1}}, -1);
    stream({128{1'b1}}, 1'b0, '0, -1);

    // Reset during the start bit of byte 5
    r1 = rnd_blk();
    offer(r1);
    stream(r1, 1'b0, '0, 5 * 10 * CPB + 1);
    chk("tx_low_before_reset", tx, 0);
    reset = 1'b0;
    #1;
    chk("abort_tx", tx, 1);
    chk("abort_ready", cypher_ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    idle_bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (tx !== 1'b1 || cypher_ready !== 1'b1 || done !== 1'b0)
        idle_bad++;
      @(negedge clk);
    end
    chk("no_resume_after_reset", idle_bad, 0);
    r2 = rnd_blk();
    offer(r2);
    stream(r2, 1'b0, '0, -1);

    // Random blocks
    for (int k = 0; k < 3; k++) begin
      r1 = rnd_blk();
      offer(r1);
      stream(r1, 1'b0, '0, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
